solicitador_leituras: RTL and testbench

//  Per-expander read requester, one instance per EA lane, directly upstream of gerenciador_leituras.

---
 rtl/solicitador_leituras.sv | 125 ++++++++++++
 tb/tb_solicitador_leituras.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/solicitador_leituras.sv
// Per-lane read requester: latches one address job, requests the arbiter until granted,
// captures the returned words after MEM_LATENCY cycles and holds them until acknowledged.
module solicitador_leituras #(
    parameter int NUM_READ_PORTS = 8,
    parameter int DATA_WIDH      = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int MEM_LATENCY    = 1,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start_in,
    input  logic [ADDR_WIDTH*NUM_READ_PORTS-1:0] addr_in,
    input  logic [NUM_READ_PORTS-1:0]            mask_in,
    output logic                                 busy_out,
    output logic                                 lvv_read_en_out,
    output logic [ADDR_WIDTH*NUM_READ_PORTS-1:0] lvv_read_addr_out,
    input  logic                                 ready_in,
    input  logic [DATA_WIDH*NUM_READ_PORTS-1:0]  read_data_in,
    output logic                                 done_out,
    output logic [DATA_WIDH*NUM_READ_PORTS-1:0]  data_out,
    output logic [NUM_READ_PORTS-1:0]            mask_out,
    input  logic                                 done_ack_in,
    output logic [CNT_WIDTH-1:0]                 wait_cycles_out,
    output logic [1:0]                           dbg_state_out
);

    // Handshakes: lvv_read_en_out is held high until a one-cycle ready_in grant;
    // done_out is held high until a one-cycle done_ack_in; start_in is taken only while idle.
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_REQ       = 2'd1,
        S_WAIT_DATA = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    localparam logic [2:0]           LAT_INIT = 3'(MEM_LATENCY);
    localparam logic [2:0]           LAT_ONE  = 3'd1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

    state_t                                r_state;
    state_t                                w_next;
    logic [2:0]                            r_lat;
    logic [CNT_WIDTH-1:0]                  r_wait;
    logic [ADDR_WIDTH*NUM_READ_PORTS-1:0]  r_addr;
    logic [DATA_WIDH*NUM_READ_PORTS-1:0]   r_data;
    logic [NUM_READ_PORTS-1:0]             r_mask;
    logic [ADDR_WIDTH*NUM_READ_PORTS-1:0]  w_addr_masked;
    logic [DATA_WIDH*NUM_READ_PORTS-1:0]   w_data_masked;
    logic                                  w_lat_last;

    // Addresses are masked with the incoming mask, data with the accepted one.
    always_comb begin
        w_addr_masked = '0;
        w_data_masked = '0;
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            if (mask_in[p]) w_addr_masked[ADDR_WIDTH*p +: ADDR_WIDTH] = addr_in[ADDR_WIDTH*p +: ADDR_WIDTH];
            if (r_mask[p])  w_data_masked[DATA_WIDH*p +: DATA_WIDH]   = read_data_in[DATA_WIDH*p +: DATA_WIDH];
        end
    end

    assign w_lat_last = (r_lat == LAT_ONE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_in) w_next = (mask_in != '0) ? S_REQ : S_DONE;
            end
            S_REQ: begin
                if (ready_in) w_next = S_WAIT_DATA;
            end
            S_WAIT_DATA: begin
                if (w_lat_last) w_next = S_DONE;
            end
            S_DONE: begin
                if (done_ack_in) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_lat   <= '0;
            r_wait  <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_mask  <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (start_in) begin
                        r_addr <= w_addr_masked;
                        r_mask <= mask_in;
                        r_wait <= '0;
                        if (mask_in == '0) r_data <= '0;
                    end
                end
                S_REQ: begin
                    if (r_wait != CNT_MAX) r_wait <= r_wait + CNT_ONE;
                    if (ready_in) r_lat <= LAT_INIT;
                end
                S_WAIT_DATA: begin
                    r_lat <= r_lat - LAT_ONE;
                    if (w_lat_last) r_data <= w_data_masked;
                end
                default: ;
            endcase
        end
    end

    assign busy_out          = (r_state != S_IDLE);
    assign lvv_read_en_out   = (r_state == S_REQ);
    assign done_out          = (r_state == S_DONE);
    assign lvv_read_addr_out = r_addr;
    assign data_out          = r_data;
    assign mask_out          = r_mask;
    assign wait_cycles_out   = r_wait;
    assign dbg_state_out     = r_state;

endmodule

// File: tb/tb_solicitador_leituras.sv
// Directed bench for solicitador_leituras: grant timing, masking, zero-mask jobs,
// ignored strobes, wait-counter saturation and reset abort.
module tb_solicitador_leituras;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_in = 1'b0;
    logic [63:0]  addr_in = '0;
    logic [7:0]   mask_in = '0;
    logic         busy_out;
    logic         lvv_read_en_out;
    logic [63:0]  lvv_read_addr_out;
    logic         ready_in = 1'b0;
    logic [255:0] read_data_in = '0;
    logic         done_out;
    logic [255:0] data_out;
    logic [7:0]   mask_out;
    logic         done_ack_in = 1'b0;
    logic [7:0]   wait_cycles_out;
    logic [1:0]   dbg_state_out;

    int n_cmp = 0;
    int n_err = 0;

    solicitador_leituras dut (
        .clk               (clk),
        .rst               (rst),
        .start_in          (start_in),
        .addr_in           (addr_in),
        .mask_in           (mask_in),
        .busy_out          (busy_out),
        .lvv_read_en_out   (lvv_read_en_out),
        .lvv_read_addr_out (lvv_read_addr_out),
        .ready_in          (ready_in),
        .read_data_in      (read_data_in),
        .done_out          (done_out),
        .data_out          (data_out),
        .mask_out          (mask_out),
        .done_ack_in       (done_ack_in),
        .wait_cycles_out   (wait_cycles_out),
        .dbg_state_out     (dbg_state_out)
    );

    always #5 clk = ~clk;

    // Word p of the bus = base + p; non-sampled cycles carry a distinct garbage pattern.
    function automatic logic [255:0] mk_data(input logic [31:0] base);
        logic [255:0] v;
        v = '0;
        for (int p = 0; p < 8; p++) v[32*p +: 32] = base + 32'(p);
        return v;
    endfunction

    localparam logic [31:0] GARBAGE_BASE = 32'hBAD0_0000;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_start(input logic [63:0] a, input logic [7:0] m);
        addr_in  = a;
        mask_in  = m;
        start_in = 1'b1;
        step();
        start_in = 1'b0;
    endtask

    task automatic grant_and_return(input logic [255:0] d);
        ready_in = 1'b1;
        step();
        ready_in = 1'b0;
        read_data_in = d;
        step();
        read_data_in = mk_data(GARBAGE_BASE);
    endtask

    task automatic ack();
        done_ack_in = 1'b1;
        step();
        done_ack_in = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_cmp++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b exp 0", busy_out); end
        n_cmp++; if (lvv_read_en_out !== 1'b0) begin n_err++; $display("FAIL reset_en: got %b exp 0", lvv_read_en_out); end
        n_cmp++; if (lvv_read_addr_out !== 64'h0) begin n_err++; $display("FAIL reset_addr: got %h exp 0", lvv_read_addr_out); end
        n_cmp++; if (done_out !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b exp 0", done_out); end
        n_cmp++; if (data_out !== 256'h0) begin n_err++; $display("FAIL reset_data: got %h exp 0", data_out); end
        n_cmp++; if (mask_out !== 8'h0) begin n_err++; $display("FAIL reset_mask: got %h exp 0", mask_out); end
        n_cmp++; if (wait_cycles_out !== 8'h0) begin n_err++; $display("FAIL reset_wait: got %0d exp 0", wait_cycles_out); end
        n_cmp++; if (dbg_state_out !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d exp 0", dbg_state_out); end
    endtask

    task automatic test_full_mask();
        logic [255:0] d;
        d = mk_data(32'hC0DE_0100);
        read_data_in = mk_data(GARBAGE_BASE);
        issue_start(64'h0807_0605_0403_0201, 8'hFF);
        n_cmp++; if (lvv_read_en_out !== 1'b1) begin n_err++; $display("FAIL full_en_c1: got %b exp 1", lvv_read_en_out); end
        n_cmp++; if (busy_out !== 1'b1) begin n_err++; $display("FAIL full_busy: got %b exp 1", busy_out); end
        n_cmp++; if (lvv_read_addr_out !== 64'h0807_0605_0403_0201) begin n_err++; $display("FAIL full_addr: got %h exp 0807060504030201", lvv_read_addr_out); end
        step();
        n_cmp++; if (lvv_read_en_out !== 1'b1) begin n_err++; $display("FAIL full_en_c2: got %b exp 1", lvv_read_en_out); end
        step();
        n_cmp++; if (lvv_read_en_out !== 1'b1) begin n_err++; $display("FAIL full_en_c3: got %b exp 1", lvv_read_en_out); end
        ready_in = 1'b1;
        step();
        ready_in = 1'b0;
        read_data_in = d;
        n_cmp++; if (lvv_read_en_out !== 1'b0) begin n_err++; $display("FAIL full_en_drop: got %b exp 0", lvv_read_en_out); end
        n_cmp++; if (wait_cycles_out !== 8'd3) begin n_err++; $display("FAIL full_wait: got %0d exp 3", wait_cycles_out); end
        n_cmp++; if (done_out !== 1'b0) begin n_err++; $display("FAIL full_done_early: got %b exp 0", done_out); end
        step();
        read_data_in = mk_data(GARBAGE_BASE);
        n_cmp++; if (done_out !== 1'b1) begin n_err++; $display("FAIL full_done: got %b exp 1", done_out); end
        n_cmp++; if (data_out !== d) begin n_err++; $display("FAIL full_data: got %h exp %h", data_out, d); end
        n_cmp++; if (mask_out !== 8'hFF) begin n_err++; $display("FAIL full_mask: got %h exp ff", mask_out); end
        step();
        n_cmp++; if (done_out !== 1'b1 || data_out !== d) begin n_err++; $display("FAIL full_hold: done %b data %h exp 1 %h", done_out, data_out, d); end
        ack();
        n_cmp++; if (done_out !== 1'b0 || busy_out !== 1'b0) begin n_err++; $display("FAIL full_ack: done %b busy %b exp 0 0", done_out, busy_out); end
        n_cmp++; if (data_out !== d) begin n_err++; $display("FAIL full_retain: got %h exp %h", data_out, d); end
    endtask

    task automatic test_partial_mask();
        logic [255:0] d;
        logic [255:0] exp_d;
        d = mk_data(32'hDEAD_0000);
        exp_d = '0;
        exp_d[31:0]  = 32'hDEAD_0000;
        exp_d[95:64] = 32'hDEAD_0002;
        issue_start(64'hA7A6_A5A4_A3A2_A1A0, 8'b0000_0101);
        n_cmp++; if (lvv_read_addr_out !== 64'h0000_0000_00A2_00A0) begin n_err++; $display("FAIL part_addr: got %h exp 0000000000a200a0", lvv_read_addr_out); end
        grant_and_return(d);
        n_cmp++; if (data_out !== exp_d) begin n_err++; $display("FAIL part_data: got %h exp %h", data_out, exp_d); end
        n_cmp++; if (mask_out !== 8'h05) begin n_err++; $display("FAIL part_mask: got %h exp 05", mask_out); end
        n_cmp++; if (wait_cycles_out !== 8'd1) begin n_err++; $display("FAIL part_wait: got %0d exp 1", wait_cycles_out); end
        ack();
    endtask

    task automatic test_zero_mask();
        read_data_in = mk_data(32'h7777_0000);
        issue_start(64'h1111_1111_1111_1111, 8'h00);
        n_cmp++; if (done_out !== 1'b1) begin n_err++; $display("FAIL zero_done: got %b exp 1", done_out); end
        n_cmp++; if (lvv_read_en_out !== 1'b0) begin n_err++; $display("FAIL zero_en: got %b exp 0", lvv_read_en_out); end
        n_cmp++; if (data_out !== 256'h0) begin n_err++; $display("FAIL zero_data: got %h exp 0", data_out); end
        n_cmp++; if (mask_out !== 8'h0) begin n_err++; $display("FAIL zero_mask: got %h exp 0", mask_out); end
        ack();
        n_cmp++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL zero_ack: busy %b exp 0", busy_out); end
    endtask

    task automatic test_ignore();
        logic [255:0] d;
        d = mk_data(32'h5A5A_0010);
        ready_in = 1'b1;
        step();
        ready_in = 1'b0;
        n_cmp++; if (busy_out !== 1'b0 || dbg_state_out !== 2'd0) begin n_err++; $display("FAIL ign_ready_idle: busy %b state %0d exp 0 0", busy_out, dbg_state_out); end
        issue_start(64'h1122_3344_5566_7788, 8'hFF);
        issue_start(64'h99AA_BBCC_DDEE_FF00, 8'hF0);
        n_cmp++; if (lvv_read_addr_out !== 64'h1122_3344_5566_7788) begin n_err++; $display("FAIL ign_start_req: got %h exp 1122334455667788", lvv_read_addr_out); end
        n_cmp++; if (lvv_read_en_out !== 1'b1 || mask_out !== 8'hFF) begin n_err++; $display("FAIL ign_start_mask: en %b mask %h exp 1 ff", lvv_read_en_out, mask_out); end
        grant_and_return(d);
        ready_in = 1'b1;
        step();
        ready_in = 1'b0;
        n_cmp++; if (done_out !== 1'b1 || data_out !== d) begin n_err++; $display("FAIL ign_ready_done: done %b data %h exp 1 %h", done_out, data_out, d); end
        done_ack_in = 1'b1;
        start_in    = 1'b1;
        mask_in     = 8'hFF;
        step();
        done_ack_in = 1'b0;
        start_in    = 1'b0;
        n_cmp++; if (busy_out !== 1'b0 || done_out !== 1'b0) begin n_err++; $display("FAIL ign_ack_start: busy %b done %b exp 0 0", busy_out, done_out); end
        step();
        n_cmp++; if (busy_out !== 1'b0 || lvv_read_en_out !== 1'b0) begin n_err++; $display("FAIL ign_stay_idle: busy %b en %b exp 0 0", busy_out, lvv_read_en_out); end
    endtask

    task automatic test_saturate();
        logic [255:0] d;
        d = mk_data(32'h0FAB_0000);
        issue_start(64'h0102_0304_0506_0708, 8'hFF);
        repeat (254) step();
        n_cmp++; if (wait_cycles_out !== 8'd254) begin n_err++; $display("FAIL sat_254: got %0d exp 254", wait_cycles_out); end
        repeat (45) step();
        n_cmp++; if (wait_cycles_out !== 8'd255) begin n_err++; $display("FAIL sat_255: got %0d exp 255", wait_cycles_out); end
        n_cmp++; if (lvv_read_en_out !== 1'b1) begin n_err++; $display("FAIL sat_en: got %b exp 1", lvv_read_en_out); end
        grant_and_return(d);
        n_cmp++; if (done_out !== 1'b1 || data_out !== d) begin n_err++; $display("FAIL sat_done: done %b data %h exp 1 %h", done_out, data_out, d); end
        n_cmp++; if (wait_cycles_out !== 8'd255) begin n_err++; $display("FAIL sat_hold: got %0d exp 255", wait_cycles_out); end
        ack();
    endtask

    task automatic test_reset_abort();
        logic [255:0] d;
        d = mk_data(32'h4242_0000);
        issue_start(64'hF1F2_F3F4_F5F6_F7F8, 8'hFF);
        ready_in = 1'b1;
        step();
        ready_in = 1'b0;
        read_data_in = mk_data(32'h6666_0000);
        rst = 1'b1;
        step();
        rst = 1'b0;
        read_data_in = mk_data(GARBAGE_BASE);
        n_cmp++; if (busy_out !== 1'b0 || lvv_read_en_out !== 1'b0 || done_out !== 1'b0) begin n_err++; $display("FAIL abort_ctrl: busy %b en %b done %b exp 0 0 0", busy_out, lvv_read_en_out, done_out); end
        n_cmp++; if (data_out !== 256'h0 || lvv_read_addr_out !== 64'h0) begin n_err++; $display("FAIL abort_data: data %h addr %h exp 0 0", data_out, lvv_read_addr_out); end
        n_cmp++; if (mask_out !== 8'h0 || wait_cycles_out !== 8'h0) begin n_err++; $display("FAIL abort_mask_wait: mask %h wait %0d exp 0 0", mask_out, wait_cycles_out); end
        step();
        n_cmp++; if (done_out !== 1'b0) begin n_err++; $display("FAIL abort_no_done: got %b exp 0", done_out); end
        issue_start(64'h0A0B_0C0D_0E0F_1011, 8'hFF);
        step();
        grant_and_return(d);
        n_cmp++; if (done_out !== 1'b1 || data_out !== d) begin n_err++; $display("FAIL abort_new_job: done %b data %h exp 1 %h", done_out, data_out, d); end
        n_cmp++; if (wait_cycles_out !== 8'd2) begin n_err++; $display("FAIL abort_new_wait: got %0d exp 2", wait_cycles_out); end
        ack();
    endtask

    initial begin
        test_reset();
        test_full_mask();
        test_partial_mask();
        test_zero_mask();
        test_ignore();
        test_saturate();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
